// File: rtl/window_watchdog_ctrl.sv
// Windowed-watchdog sequencer: a closed first window, an open second window, and a
// timed system-reset phase on any fault. All outputs are registered.
module window_watchdog_ctrl #(
  parameter int CNT_W   = 16,
  parameter int FLCNT_W = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               INIT,
  input  logic               WDSRVC,
  input  logic [CNT_W-1:0]   FWLEN,
  input  logic [CNT_W-1:0]   SWLEN,
  input  logic [CNT_W-1:0]   RST_LMT,
  output logic [1:0]         WDSTATE,
  output logic               SYSRST,
  output logic               WDFAIL,
  output logic               SRVOK,
  output logic [2:0]         FLSTAT,
  output logic [FLCNT_W-1:0] FLCNT
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_FIRST  = 2'b01,
    S_SECOND = 2'b10,
    S_FAULT  = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0]   CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [FLCNT_W-1:0] FL_ONE  = {{(FLCNT_W-1){1'b0}}, 1'b1};
  localparam logic [FLCNT_W-1:0] FL_MAX  = {FLCNT_W{1'b1}};

  localparam logic [2:0] CODE_NONE  = 3'b000;
  localparam logic [2:0] CODE_EARLY = 3'b001;
  localparam logic [2:0] CODE_TMO   = 3'b010;
  localparam logic [2:0] CODE_SAT   = 3'b100;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               srv_q;
  logic               sysrst_q, sysrst_d;
  logic               wdfail_q, wdfail_d;
  logic               srvok_q, srvok_d;
  logic [2:0]         flstat_q, flstat_d;
  logic [FLCNT_W-1:0] flcnt_q, flcnt_d;

  logic       srv_edge;
  logic       first_last, second_last, fault_last;
  logic       fault_entry;
  logic [2:0] fault_code;

  assign srv_edge = WDSRVC & ~srv_q;

  // A zero length behaves as one cycle; lengths are compared live so a shrink ends the window next cycle.
  assign first_last  = (FWLEN   == '0) || (cnt_q >= FWLEN   - CNT_ONE);
  assign second_last = (SWLEN   == '0) || (cnt_q >= SWLEN   - CNT_ONE);
  assign fault_last  = (RST_LMT == '0) || (cnt_q >= RST_LMT - CNT_ONE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wdfail_d    = 1'b0;
    srvok_d     = 1'b0;
    flstat_d    = flstat_q;
    flcnt_d     = flcnt_q;
    fault_entry = 1'b0;
    fault_code  = CODE_NONE;

    if (INIT) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      flstat_d = CODE_NONE;
      flcnt_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_FIRST;
          cnt_d   = '0;
        end
        S_FIRST: begin
          if (srv_edge) begin
            fault_entry = 1'b1;
            fault_code  = CODE_EARLY;
          end else if (first_last) begin
            state_d = S_SECOND;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_SECOND: begin
          if (srv_edge) begin
            state_d = S_FIRST;
            cnt_d   = '0;
            srvok_d = 1'b1;
          end else if (second_last) begin
            fault_entry = 1'b1;
            fault_code  = CODE_TMO;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_FAULT: begin
          if (fault_last) begin
            state_d = S_FIRST;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase

      // A saturated fault counter is reported in place of the window code.
      if (fault_entry) begin
        state_d  = S_FAULT;
        cnt_d    = '0;
        wdfail_d = 1'b1;
        if (flcnt_q == FL_MAX) begin
          flstat_d = CODE_SAT;
        end else begin
          flcnt_d  = flcnt_q + FL_ONE;
          flstat_d = fault_code;
        end
      end
    end

    sysrst_d = (state_d == S_FAULT);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      srv_q    <= 1'b0;
      sysrst_q <= 1'b0;
      wdfail_q <= 1'b0;
      srvok_q  <= 1'b0;
      flstat_q <= CODE_NONE;
      flcnt_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      srv_q    <= WDSRVC;
      sysrst_q <= sysrst_d;
      wdfail_q <= wdfail_d;
      srvok_q  <= srvok_d;
      flstat_q <= flstat_d;
      flcnt_q  <= flcnt_d;
    end
  end

  assign WDSTATE = state_q;
  assign SYSRST  = sysrst_q;
  assign WDFAIL  = wdfail_q;
  assign SRVOK   = srvok_q;
  assign FLSTAT  = flstat_q;
  assign FLCNT   = flcnt_q;

endmodule

// File: tb/tb_window_watchdog_ctrl.sv
// Bench for window_watchdog_ctrl: two instances (8-bit and 2-bit fault counters) share
// stimulus and are checked against a phase/age reference model through an expected queue.
module tb_window_watchdog_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, init, srv;
  logic [15:0] fw, sw, rl;

  logic [1:0] a_st, b_st;
  logic       a_sysrst, a_wdfail, a_srvok, b_sysrst, b_wdfail, b_srvok;
  logic [2:0] a_fs, b_fs;
  logic [7:0] a_fc;
  logic [1:0] b_fc;

  window_watchdog_ctrl #(.CNT_W(16), .FLCNT_W(8)) dut_a (
    .CLK(clk), .RST(rst), .INIT(init), .WDSRVC(srv),
    .FWLEN(fw), .SWLEN(sw), .RST_LMT(rl),
    .WDSTATE(a_st), .SYSRST(a_sysrst), .WDFAIL(a_wdfail), .SRVOK(a_srvok),
    .FLSTAT(a_fs), .FLCNT(a_fc)
  );

  window_watchdog_ctrl #(.CNT_W(16), .FLCNT_W(2)) dut_b (
    .CLK(clk), .RST(rst), .INIT(init), .WDSRVC(srv),
    .FWLEN(fw), .SWLEN(sw), .RST_LMT(rl),
    .WDSTATE(b_st), .SYSRST(b_sysrst), .WDFAIL(b_wdfail), .SRVOK(b_srvok),
    .FLSTAT(b_fs), .FLCNT(b_fc)
  );

  typedef struct packed {
    logic [1:0] st;
    logic       sysrst;
    logic       wdfail;
    logic       srvok;
    logic [2:0] fs8;
    logic [7:0] fc8;
    logic [2:0] fs2;
    logic [1:0] fc2;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: phase 0 idle, 1 first, 2 second, 3 fault; age = cycles already spent in phase.
  int m_phase = 0;
  int m_age   = 0;
  bit m_prev  = 0;
  bit m_wdfail = 0;
  bit m_srvok  = 0;
  int m_fs[2] = '{0, 0};
  int m_fc[2] = '{0, 0};
  int fl_max[2] = '{255, 3};

  logic [15:0] c_fw = 16'd4;
  logic [15:0] c_sw = 16'd3;
  logic [15:0] c_rl = 16'd5;

  function automatic int eff(input logic [15:0] v);
    return (v == 16'd0) ? 1 : int'(v);
  endfunction

  task automatic model_fault(input int code);
    m_phase  = 3;
    m_age    = 0;
    m_wdfail = 1;
    for (int i = 0; i < 2; i++) begin
      if (m_fc[i] == fl_max[i]) m_fs[i] = 4;
      else begin
        m_fc[i] = m_fc[i] + 1;
        m_fs[i] = code;
      end
    end
  endtask

  task automatic model_step(input bit r, input bit in, input bit s);
    bit edge_s;
    edge_s   = s && !m_prev;
    m_prev   = r ? 1'b0 : s;
    m_wdfail = 0;
    m_srvok  = 0;
    if (r || in) begin
      m_phase = 0;
      m_age   = 0;
      m_fs    = '{0, 0};
      m_fc    = '{0, 0};
    end else begin
      case (m_phase)
        0: begin m_phase = 1; m_age = 0; end
        1: begin
          if (edge_s) model_fault(1);
          else if (m_age + 1 >= eff(c_fw)) begin m_phase = 2; m_age = 0; end
          else m_age++;
        end
        2: begin
          if (edge_s) begin m_phase = 1; m_age = 0; m_srvok = 1; end
          else if (m_age + 1 >= eff(c_sw)) model_fault(2);
          else m_age++;
        end
        default: begin
          if (m_age + 1 >= eff(c_rl)) begin m_phase = 1; m_age = 0; end
          else m_age++;
        end
      endcase
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the response due after the next rising edge.
  task automatic drive(input bit r, input bit in, input bit s);
    exp_t e;
    @(negedge clk);
    rst  = r;
    init = in;
    srv  = s;
    fw   = c_fw;
    sw   = c_sw;
    rl   = c_rl;
    model_step(r, in, s);
    e.st     = 2'(m_phase);
    e.sysrst = (m_phase == 3);
    e.wdfail = m_wdfail;
    e.srvok  = m_srvok;
    e.fs8    = 3'(m_fs[0]);
    e.fc8    = 8'(m_fc[0]);
    e.fs2    = 3'(m_fs[1]);
    e.fc2    = 2'(m_fc[1]);
    exp_q.push_back(e);
  endtask

  task automatic idle_cycles(input int n, input bit s);
    for (int i = 0; i < n; i++) drive(0, 0, s);
  endtask

  task automatic go_to(input int ph, input int age);
    int n;
    n = 0;
    while (!(m_phase == ph && m_age == age) && n < 200) begin
      drive(0, 0, 0);
      n++;
    end
    if (n >= 200) begin
      n_checks++;
      n_errors++;
      $display("FAIL go_to: phase %0d age %0d not reached within 200 cycles", ph, age);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("a_wdstate", int'(a_st),     int'(e.st));
      chk("a_sysrst",  int'(a_sysrst), int'(e.sysrst));
      chk("a_wdfail",  int'(a_wdfail), int'(e.wdfail));
      chk("a_srvok",   int'(a_srvok),  int'(e.srvok));
      chk("a_flstat",  int'(a_fs),     int'(e.fs8));
      chk("a_flcnt",   int'(a_fc),     int'(e.fc8));
      chk("b_wdstate", int'(b_st),     int'(e.st));
      chk("b_sysrst",  int'(b_sysrst), int'(e.sysrst));
      chk("b_wdfail",  int'(b_wdfail), int'(e.wdfail));
      chk("b_srvok",   int'(b_srvok),  int'(e.srvok));
      chk("b_flstat",  int'(b_fs),     int'(e.fs2));
      chk("b_flcnt",   int'(b_fc),     int'(e.fc2));
    end
  end

  initial begin
    rst  = 1'b1;
    init = 1'b0;
    srv  = 1'b0;
    fw   = 16'd4;
    sw   = 16'd3;
    rl   = 16'd5;

    for (int i = 0; i < 3; i++) drive(1, 0, 0);

    // Unserviced run: first window, second window, timeout fault, reset phase.
    idle_cycles(14, 0);

    // Early service in the second cycle of the closed window.
    go_to(1, 1);
    drive(0, 0, 1);
    idle_cycles(8, 0);

    // Service in the last open-window cycle, then the level is held high.
    go_to(2, 2);
    for (int i = 0; i < 10; i++) drive(0, 0, 1);
    drive(0, 0, 0);

    // Service in the last closed-window cycle, then all lengths zero.
    go_to(1, 3);
    drive(0, 0, 1);
    c_fw = 16'd0; c_sw = 16'd0; c_rl = 16'd0;
    idle_cycles(10, 0);

    // INIT while in a long reset phase, then RST in the open window.
    c_fw = 16'd4; c_sw = 16'd3; c_rl = 16'd10;
    go_to(3, 3);
    drive(0, 1, 0);
    idle_cycles(3, 0);
    go_to(2, 1);
    drive(1, 0, 0);
    idle_cycles(2, 0);

    // Back-to-back timeouts to saturate the narrow fault counter.
    c_fw = 16'd1; c_sw = 16'd1; c_rl = 16'd1;
    idle_cycles(24, 0);

    // Randomized traffic including live length changes, INIT and RST.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) c_fw = 16'($urandom_range(0, 6));
      if ($urandom_range(0, 39) == 0) c_sw = 16'($urandom_range(0, 6));
      if ($urandom_range(0, 39) == 0) c_rl = 16'($urandom_range(0, 6));
      drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 59) == 0),
            ($urandom_range(0, 3) == 0));
    end

    @(posedge clk);
    @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/window_watchdog_ctrl.md
Name: window_watchdog_ctrl

Overview:
- Windowed-watchdog sequencer. It is driven by the configuration register outputs FWLEN, SWLEN, RST_LMT, WDSRVC and INIT.
- It times a closed first window and an open second window, and qualifies each service event against them.
- On a fault it records a failure code and asserts the system reset output for a programmable number of cycles.
- It sits between the configuration register and the system reset / status logic.

Parameters:
- CNT_W, 16, width of the window counter and of the FWLEN/SWLEN/RST_LMT inputs.
- FLCNT_W, 8, width of the saturating fault counter.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- INIT  in  1  level; while 1 the watchdog is held idle.
- WDSRVC  in  1  service bit; each rising edge is one service event.
- FWLEN  in  CNT_W  closed (first) window length, in cycles.
- SWLEN  in  CNT_W  open (second) window length, in cycles.
- RST_LMT  in  CNT_W  SYSRST pulse length, in cycles.
- WDSTATE  out  2  current state: 00 IDLE, 01 FIRST, 10 SECOND, 11 FAULT.
- SYSRST  out  1  system reset request, high throughout FAULT.
- WDFAIL  out  1  one-cycle pulse on each entry to FAULT.
- SRVOK  out  1  one-cycle pulse on each accepted service.
- FLSTAT  out  3  last failure code.
- FLCNT  out  FLCNT_W  number of faults since IDLE/reset; saturates.

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high. All outputs are registered.
- RST=1 forces state=IDLE, cnt=0, srv_q=0, SYSRST=0, WDFAIL=0, SRVOK=0, FLSTAT=000, FLCNT=0.
- Service edge: srv_q<=WDSRVC every cycle, including IDLE. srv_edge = WDSRVC & ~srv_q. A WDSRVC level held high gives exactly one event.
- Effective lengths: Fe = max(FWLEN,1), Se = max(SWLEN,1), Re = max(RST_LMT,1).
- Lengths are compared live each cycle using cnt >= L-1. If a length is shrunk below cnt mid-window, the window ends on the next cycle.
- Priority per cycle: RST > INIT > state logic.
- INIT=1 in any state: next state IDLE, cnt=0, FLSTAT=000, FLCNT=0. SYSRST drops the next cycle, even mid-FAULT.
- IDLE: when INIT=0, go to FIRST with cnt=0.
- FIRST (closed window):
  - srv_edge -> FAULT, FLSTAT=001 (early service). This includes an edge in the last cycle of the window.
  - Else if cnt >= Fe-1 -> SECOND, cnt=0.
  - Else cnt+1.
- SECOND (open window):
  - srv_edge -> FIRST, cnt=0, SRVOK=1 for one cycle. This includes an edge in the last cycle of the window.
  - Else if cnt >= Se-1 -> FAULT, FLSTAT=010 (timeout).
  - Else cnt+1.
- FAULT:
  - SYSRST=1. srv_edge is ignored.
  - If cnt >= Re-1 -> FIRST, cnt=0. Else cnt+1.
- Entry into FAULT: cnt=0, WDFAIL=1 for one cycle, FLCNT+1.
- FLCNT saturation: FLCNT saturates at 2^FLCNT_W-1. When the increment would overflow, FLSTAT=100 instead of the window code.
- Latency: WDSRVC rises at sampled cycle n; the state change, SRVOK, WDFAIL and FLSTAT are all visible at n+1.
- Window timing: FIRST lasts exactly Fe cycles and SECOND at most Se cycles. SYSRST is high for exactly Re cycles.
- FLSTAT persists until INIT or RST. It is overwritten by each new fault.
- The counter never wraps: it is always cleared before reaching 2^CNT_W-1, because every length is at most 2^CNT_W-1.

Test Plan:
1. Reset, INIT=0, FWLEN=4, SWLEN=3, no service -> WDSTATE=01 for 4 cycles, then 10 for 3 cycles, then 11. WDFAIL pulses once, FLSTAT=010, FLCNT=1.
2. FWLEN=4, SWLEN=3, RST_LMT=5; service edge in the 2nd FIRST cycle -> next cycle WDSTATE=11, FLSTAT=001. SYSRST high exactly 5 cycles, then WDSTATE=01.
3. FWLEN=4, SWLEN=3; service edge in the 3rd (last) SECOND cycle -> SRVOK pulse, WDSTATE=01, cnt restarts, FLCNT unchanged. WDSRVC held high afterwards -> no further events.
4. Boundaries: service edge in the last FIRST cycle -> early fault (001). FWLEN=SWLEN=RST_LMT=0 -> each phase lasts 1 cycle.
5. INIT=1 during FAULT with RST_LMT=10 -> SYSRST=0 and WDSTATE=00 next cycle, FLSTAT=000, FLCNT=0. RST=1 mid-SECOND -> all outputs at reset values next cycle.
6. FLCNT_W=2: four consecutive timeouts -> FLCNT stays at 3, and FLSTAT=100 on the 4th fault.
